// File: rtl/execute_stage.sv
// RV32I integer execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register with a one-shot redirect toward fetch.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module execute_stage #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  alu_pkg::aluop_t     id_aluop_i,
  input  logic [2:0]          id_funct3_i,
  input  logic [XLEN-1:0]     id_pc_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic [4:0]          id_rs1_addr_i,
  input  logic [4:0]          id_rs2_addr_i,
  input  logic [XLEN-1:0]     id_rs1_data_i,
  input  logic [XLEN-1:0]     id_rs2_data_i,
  input  logic [4:0]          id_rd_addr_i,
  input  logic                id_reg_we_i,
  input  logic                id_use_imm_i,
  input  logic                id_use_pc_i,
  input  logic                id_branch_i,
  input  logic                id_jump_i,
  input  logic                id_jalr_i,
  input  logic                wb_reg_we_i,
  input  logic [4:0]          wb_rd_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic                ex_valid_o,
  output logic [XLEN-1:0]     ex_result_o,
  output logic [XLEN-1:0]     ex_store_data_o,
  output logic [4:0]          ex_rd_addr_o,
  output logic                ex_reg_we_o,
  output logic                redirect_o,
  output logic [XLEN-1:0]     redirect_pc_o
);

  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, jalr_sum, target;
  logic            br_eq, br_lt, br_ltu, br_cond, taken;

  logic            valid_d, we_d, redirect_d;
  logic [XLEN-1:0] result_d, store_d, redirect_pc_d;
  logic [4:0]      rd_d;

  // EX/MEM beats WB; x0 is never forwarded; bubbles in EX/MEM are ignored
  always_comb begin
    fwd_rs1 = id_rs1_data_i;
    fwd_rs2 = id_rs2_data_i;
    if (ex_valid_o && ex_reg_we_o && (ex_rd_addr_o != 5'd0) && (ex_rd_addr_o == id_rs1_addr_i))
      fwd_rs1 = ex_result_o;
    else if (wb_reg_we_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == id_rs1_addr_i))
      fwd_rs1 = wb_data_i;
    if (ex_valid_o && ex_reg_we_o && (ex_rd_addr_o != 5'd0) && (ex_rd_addr_o == id_rs2_addr_i))
      fwd_rs2 = ex_result_o;
    else if (wb_reg_we_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == id_rs2_addr_i))
      fwd_rs2 = wb_data_i;
  end

  assign op_a = id_use_pc_i  ? id_pc_i  : fwd_rs1;
  assign op_b = id_use_imm_i ? id_imm_i : fwd_rs2;

  always_comb begin
    alu_res = '0;
    case (id_aluop_i)
      alu_pkg::ALU_ADD:  alu_res = op_a + op_b;
      alu_pkg::ALU_SUB:  alu_res = op_a - op_b;
      alu_pkg::ALU_AND:  alu_res = op_a & op_b;
      alu_pkg::ALU_OR:   alu_res = op_a | op_b;
      alu_pkg::ALU_XOR:  alu_res = op_a ^ op_b;
      alu_pkg::ALU_SLL:  alu_res = op_a << op_b[4:0];
      alu_pkg::ALU_SRL:  alu_res = op_a >> op_b[4:0];
      alu_pkg::ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> op_b[4:0]);
      alu_pkg::ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      alu_pkg::ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      default:           alu_res = '0;
    endcase
  end

  // Branch conditions compare the forwarded registers, never the operand muxes
  assign br_eq  = (fwd_rs1 == fwd_rs2);
  assign br_lt  = ($signed(fwd_rs1) < $signed(fwd_rs2));
  assign br_ltu = (fwd_rs1 < fwd_rs2);

  always_comb begin
    br_cond = 1'b0;
    case (id_funct3_i)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = !br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign taken    = id_jump_i | (id_branch_i & br_cond);
  assign jalr_sum = fwd_rs1 + id_imm_i;
  assign target   = id_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc_i + id_imm_i);

  // Capture priority: flush, self-squash behind a redirect, stall, normal
  always_comb begin
    valid_d       = ex_valid_o;
    we_d          = ex_reg_we_o;
    redirect_d    = redirect_o;
    result_d      = ex_result_o;
    store_d       = ex_store_data_o;
    rd_d          = ex_rd_addr_o;
    redirect_pc_d = redirect_pc_o;
    if (flush_i || redirect_o) begin
      valid_d    = 1'b0;
      we_d       = 1'b0;
      redirect_d = 1'b0;
    end else if (stall_i) begin
      redirect_d = 1'b0;
    end else begin
      valid_d    = id_valid_i;
      we_d       = id_valid_i & id_reg_we_i & ~id_branch_i;
      redirect_d = id_valid_i & taken;
      result_d   = id_jump_i ? (id_pc_i + XLEN'(4)) : alu_res;
      store_d    = fwd_rs2;
      rd_d       = id_rd_addr_i;
      if (id_valid_i && taken) redirect_pc_d = target;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_valid_o      <= 1'b0;
      ex_reg_we_o     <= 1'b0;
      redirect_o      <= 1'b0;
      ex_result_o     <= '0;
      ex_store_data_o <= '0;
      ex_rd_addr_o    <= 5'd0;
      redirect_pc_o   <= XLEN'(RESET_PC_UNUSED);
    end else begin
      ex_valid_o      <= valid_d;
      ex_reg_we_o     <= we_d;
      redirect_o      <= redirect_d;
      ex_result_o     <= result_d;
      ex_store_data_o <= store_d;
      ex_rd_addr_o    <= rd_d;
      redirect_pc_o   <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed expectations.
module tb_execute_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stall_i, flush_i, id_valid_i;
  aluop_t      id_aluop_i;
  logic [2:0]  id_funct3_i;
  logic [31:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i, wb_data_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_rd_addr_i;
  logic        id_reg_we_i, id_use_imm_i, id_use_pc_i, id_branch_i, id_jump_i, id_jalr_i;
  logic        wb_reg_we_i;
  logic        ex_valid_o, ex_reg_we_o, redirect_o;
  logic [31:0] ex_result_o, ex_store_data_o, redirect_pc_o;
  logic [4:0]  ex_rd_addr_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .RESET_PC_UNUSED(0)) dut (
    .clk(clk), .arst_n(arst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_aluop_i(id_aluop_i), .id_funct3_i(id_funct3_i),
    .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_rd_addr_i(id_rd_addr_i), .id_reg_we_i(id_reg_we_i),
    .id_use_imm_i(id_use_imm_i), .id_use_pc_i(id_use_pc_i),
    .id_branch_i(id_branch_i), .id_jump_i(id_jump_i), .id_jalr_i(id_jalr_i),
    .wb_reg_we_i(wb_reg_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_result_o(ex_result_o), .ex_store_data_o(ex_store_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_we_o(ex_reg_we_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  logic [3:0]  sweep_op  [0:10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
  logic [31:0] sweep_b   [0:10] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5};
  logic [31:0] sweep_exp [0:10] = '{32'h2, 32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'hFFFF_FFF8,
                                    32'hFFFF_FFFA, 32'h7FFF_FFFE, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    stall_i = 0; flush_i = 0; id_valid_i = 0; id_aluop_i = ALU_ADD; id_funct3_i = 3'd0;
    id_pc_i = 0; id_imm_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; id_rd_addr_i = 0; id_reg_we_i = 0;
    id_use_imm_i = 0; id_use_pc_i = 0; id_branch_i = 0; id_jump_i = 0; id_jalr_i = 0;
    wb_reg_we_i = 0; wb_rd_addr_i = 0; wb_data_i = 0;
  endtask

  task automatic add_op(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
    clear_id();
    id_valid_i = 1; id_aluop_i = ALU_ADD; id_reg_we_i = 1; id_rd_addr_i = rd;
    id_rs1_addr_i = rs1; id_rs1_data_i = d1; id_rs2_addr_i = rs2; id_rs2_data_i = d2;
  endtask

  task automatic branch_op(input logic [2:0] f3, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] pc, input logic [31:0] imm);
    clear_id();
    id_valid_i = 1; id_branch_i = 1; id_funct3_i = f3; id_reg_we_i = 1; id_rd_addr_i = 5'd12;
    id_rs1_addr_i = 5'd1; id_rs1_data_i = d1; id_rs2_addr_i = 5'd2; id_rs2_data_i = d2;
    id_pc_i = pc; id_imm_i = imm;
  endtask

  task automatic test_reset();
    arst_n = 0;
    clear_id();
    #12;
    total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ex_valid_o); else pass_cnt++;
    total_cnt++; if (ex_result_o !== 32'h0) $display("FAIL reset_result: got %h expected 0", ex_result_o); else pass_cnt++;
    total_cnt++; if (redirect_o !== 1'b0) $display("FAIL reset_redirect: got %b expected 0", redirect_o); else pass_cnt++;
    total_cnt++; if (redirect_pc_o !== 32'h0) $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc_o); else pass_cnt++;
    @(posedge clk);
    #2 arst_n = 1;
  endtask

  task automatic test_alu_sweep();
    for (int i = 0; i < 11; i++) begin
      add_op(5'd1, 32'hFFFF_FFFD, 5'd2, sweep_b[i], 5'd10);
      id_aluop_i = aluop_t'(sweep_op[i]);
      tick();
      total_cnt++;
      if (ex_result_o !== sweep_exp[i])
        $display("FAIL alu_op%0d: got %h expected %h", sweep_op[i], ex_result_o, sweep_exp[i]);
      else pass_cnt++;
    end
    total_cnt++; if (ex_reg_we_o !== 1'b1) $display("FAIL alu_we: got %b expected 1", ex_reg_we_o); else pass_cnt++;
    add_op(5'd1, 32'h7, 5'd2, 32'h9, 5'd10);
    id_use_pc_i = 1; id_use_imm_i = 1; id_pc_i = 32'h1000; id_imm_i = 32'h2000;
    tick();
    total_cnt++; if (ex_result_o !== 32'h3000) $display("FAIL auipc_operands: got %h expected 3000", ex_result_o); else pass_cnt++;
  endtask

  task automatic test_forwarding();
    add_op(5'd1, 32'd3, 5'd2, 32'd4, 5'd5);
    tick();
    total_cnt++; if (ex_result_o !== 32'd7) $display("FAIL fwd_producer: got %0d expected 7", ex_result_o); else pass_cnt++;
    add_op(5'd5, 32'd1, 5'd5, 32'd1, 5'd6);
    wb_reg_we_i = 1; wb_rd_addr_i = 5'd5; wb_data_i = 32'd99;
    tick();
    total_cnt++; if (ex_result_o !== 32'd14) $display("FAIL fwd_exmem_wins: got %0d expected 14", ex_result_o); else pass_cnt++;
    total_cnt++; if (ex_store_data_o !== 32'd7) $display("FAIL fwd_store_data: got %0d expected 7", ex_store_data_o); else pass_cnt++;
    add_op(5'd5, 32'd1, 5'd3, 32'd2, 5'd7);
    wb_reg_we_i = 1; wb_rd_addr_i = 5'd5; wb_data_i = 32'd99;
    tick();
    total_cnt++; if (ex_result_o !== 32'd101) $display("FAIL fwd_wb: got %0d expected 101", ex_result_o); else pass_cnt++;
    add_op(5'd1, 32'd10, 5'd2, 32'd20, 5'd0);
    tick();
    add_op(5'd0, 32'd1, 5'd0, 32'd2, 5'd8);
    wb_reg_we_i = 1; wb_rd_addr_i = 5'd0; wb_data_i = 32'd55;
    tick();
    total_cnt++; if (ex_result_o !== 32'd3) $display("FAIL fwd_x0: got %0d expected 3", ex_result_o); else pass_cnt++;
    add_op(5'd1, 32'd2, 5'd2, 32'd3, 5'd9);
    id_valid_i = 0;
    tick();
    total_cnt++; if ({ex_valid_o, ex_reg_we_o, redirect_o} !== 3'b000) $display("FAIL bubble_flags: got %b expected 000", {ex_valid_o, ex_reg_we_o, redirect_o}); else pass_cnt++;
    add_op(5'd9, 32'd4, 5'd2, 32'd0, 5'd11);
    tick();
    total_cnt++; if (ex_result_o !== 32'd4) $display("FAIL bubble_no_fwd: got %0d expected 4", ex_result_o); else pass_cnt++;
  endtask

  task automatic test_branch();
    branch_op(3'b000, 32'd8, 32'd8, 32'h100, 32'h20);
    tick();
    total_cnt++; if (redirect_o !== 1'b1) $display("FAIL beq_redirect: got %b expected 1", redirect_o); else pass_cnt++;
    total_cnt++; if (redirect_pc_o !== 32'h120) $display("FAIL beq_target: got %h expected 120", redirect_pc_o); else pass_cnt++;
    total_cnt++; if ({ex_valid_o, ex_reg_we_o} !== 2'b10) $display("FAIL beq_valid_we: got %b expected 10", {ex_valid_o, ex_reg_we_o}); else pass_cnt++;
    add_op(5'd1, 32'd1, 5'd2, 32'd2, 5'd13);
    tick();
    total_cnt++; if ({ex_valid_o, redirect_o} !== 2'b00) $display("FAIL self_squash: got %b expected 00", {ex_valid_o, redirect_o}); else pass_cnt++;
    add_op(5'd1, 32'd1, 5'd2, 32'd2, 5'd13);
    tick();
    total_cnt++; if ({ex_valid_o, ex_result_o} !== {1'b1, 32'd3}) $display("FAIL after_squash: got %b/%0d expected 1/3", ex_valid_o, ex_result_o); else pass_cnt++;
    branch_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF0);
    tick();
    total_cnt++; if ({ex_valid_o, redirect_o} !== 2'b10) $display("FAIL bltu_not_taken: got %b expected 10", {ex_valid_o, redirect_o}); else pass_cnt++;
    branch_op(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF0);
    tick();
    total_cnt++; if ({redirect_o, redirect_pc_o} !== {1'b1, 32'h1F0}) $display("FAIL blt_taken: got %b/%h expected 1/1f0", redirect_o, redirect_pc_o); else pass_cnt++;
    clear_id();
    tick();
  endtask

  task automatic test_jumps();
    clear_id();
    id_valid_i = 1; id_jump_i = 1; id_jalr_i = 1; id_use_imm_i = 1; id_reg_we_i = 1; id_rd_addr_i = 5'd1;
    id_pc_i = 32'h40; id_imm_i = 32'h0; id_rs1_addr_i = 5'd3; id_rs1_data_i = 32'h203;
    tick();
    total_cnt++; if (ex_result_o !== 32'h44) $display("FAIL jalr_link: got %h expected 44", ex_result_o); else pass_cnt++;
    total_cnt++; if (redirect_pc_o !== 32'h202) $display("FAIL jalr_target: got %h expected 202", redirect_pc_o); else pass_cnt++;
    total_cnt++; if ({ex_reg_we_o, redirect_o} !== 2'b11) $display("FAIL jalr_we_redirect: got %b expected 11", {ex_reg_we_o, redirect_o}); else pass_cnt++;
    clear_id();
    tick();
    total_cnt++; if ({redirect_o, redirect_pc_o} !== {1'b0, 32'h202}) $display("FAIL jalr_pc_hold: got %b/%h expected 0/202", redirect_o, redirect_pc_o); else pass_cnt++;
    clear_id();
    id_valid_i = 1; id_jump_i = 1; id_reg_we_i = 1; id_rd_addr_i = 5'd1; id_pc_i = 32'h80; id_imm_i = 32'h10;
    tick();
    total_cnt++; if ({ex_result_o, redirect_pc_o} !== {32'h84, 32'h90}) $display("FAIL jal: got %h/%h expected 84/90", ex_result_o, redirect_pc_o); else pass_cnt++;
    clear_id();
    tick();
  endtask

  task automatic test_stall_flush();
    add_op(5'd1, 32'd5, 5'd2, 32'd6, 5'd14);
    tick();
    add_op(5'd1, 32'd100, 5'd2, 32'd6, 5'd15);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({ex_valid_o, ex_rd_addr_o, ex_result_o} !== {1'b1, 5'd14, 32'd11})
        $display("FAIL stall_hold%0d: got %b/%0d/%0d expected 1/14/11", i, ex_valid_o, ex_rd_addr_o, ex_result_o);
      else pass_cnt++;
    end
    branch_op(3'b000, 32'd3, 32'd3, 32'h300, 32'h8);
    tick();
    total_cnt++; if (redirect_o !== 1'b1) $display("FAIL stall_branch_redirect: got %b expected 1", redirect_o); else pass_cnt++;
    add_op(5'd1, 32'd1, 5'd2, 32'd1, 5'd16);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({redirect_o, redirect_pc_o} !== {1'b0, 32'h308})
        $display("FAIL stall_redirect%0d: got %b/%h expected 0/308", i, redirect_o, redirect_pc_o);
      else pass_cnt++;
    end
    add_op(5'd1, 32'd1, 5'd2, 32'd1, 5'd16);
    tick();
    flush_i = 1; stall_i = 1;
    tick();
    total_cnt++; if ({ex_valid_o, ex_reg_we_o} !== 2'b00) $display("FAIL flush_over_stall: got %b expected 00", {ex_valid_o, ex_reg_we_o}); else pass_cnt++;
    clear_id();
    tick();
  endtask

  task automatic test_reset_mid();
    branch_op(3'b000, 32'd4, 32'd4, 32'h500, 32'h4);
    tick();
    total_cnt++; if ({ex_valid_o, redirect_o} !== 2'b11) $display("FAIL pre_reset: got %b expected 11", {ex_valid_o, redirect_o}); else pass_cnt++;
    #2 arst_n = 0;
    #1;
    total_cnt++;
    if ({ex_valid_o, ex_reg_we_o, redirect_o, ex_result_o, redirect_pc_o, ex_rd_addr_o} !== 72'h0)
      $display("FAIL async_reset: got %b%b%b %h %h %0d expected all 0", ex_valid_o, ex_reg_we_o, redirect_o, ex_result_o, redirect_pc_o, ex_rd_addr_o);
    else pass_cnt++;
    tick();
    arst_n = 1;
    add_op(5'd1, 32'd2, 5'd2, 32'd3, 5'd4);
    total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL post_reset_idle: got %b expected 0", ex_valid_o); else pass_cnt++;
    tick();
    total_cnt++; if ({ex_valid_o, ex_result_o} !== {1'b1, 32'd5}) $display("FAIL post_reset_first: got %b/%0d expected 1/5", ex_valid_o, ex_result_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_sweep();
    test_forwarding();
    test_branch();
    test_jumps();
    test_stall_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
